// File: rtl/ml_model_sched.sv
// ml_model_sched
//   Issue/credit controller around the fixed-latency ml_model pipeline.
//   Input vectors are accepted over valid/ready and driven straight onto
//   model_inp. A valid shift register, as long as the pipeline latency, marks
//   which model_out beats carry real results. Those beats are written into a
//   result FIFO that drains over valid/ready. The controller accepts a new
//   vector only while fewer than FIFO_DEPTH vectors are outstanding, so every
//   result has a FIFO slot even under output backpressure.
//
// Ports
//   clk        clock, rising edge
//   resetn     asynchronous active-low reset
//   enable     level, 1 = accept new vectors
//   flush      1-cycle pulse, discard everything outstanding
//   in_valid   input vector valid
//   in_ready   controller can accept in_data this cycle
//   in_data    input vector
//   model_inp  to ml_model (combinational copy of in_data)
//   model_out  from ml_model
//   out_valid  result FIFO non-empty (and not flushing)
//   out_ready  consumer takes out_data
//   out_data   FIFO head result
//   used       outstanding vectors (pipeline + FIFO)
//   busy       used != 0 or flushing
//   err_ovf    sticky, FIFO written while full without a pop
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | not accepting; in-flight results still captured/popped
// RUN   | accepting vectors while credits remain
// FLUSH | discarding; waits for the valid shift register to drain

module ml_model_sched #(
    parameter int IN_W       = 120,
    parameter int OUT_W      = 140,
    parameter int LATENCY    = 6,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          enable,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [IN_W-1:0]               in_data,
    output logic [IN_W-1:0]               model_inp,
    input  logic [OUT_W-1:0]              model_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_W-1:0]              out_data,
    output logic [$clog2(FIFO_DEPTH):0]   used,
    output logic                          busy,
    output logic                          err_ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t               state;
    logic [LATENCY-1:0]   vsr;
    logic [OUT_W-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;

    logic accept;
    logic pop;
    logic wr;
    logic full;
    logic flush_done;

    assign model_inp  = in_data;
    // Credit check uses registered state only, so there is no in_valid->in_ready path.
    assign in_ready   = (state == RUN) && (used < DEPTH_C);
    assign accept     = in_valid & in_ready;
    assign out_valid  = (count != '0) && (state != FLUSH);
    assign pop        = out_valid & out_ready;
    // A result landing on the flush edge is dropped along with the FIFO contents.
    assign wr         = vsr[LATENCY-1] && (state != FLUSH) && !flush;
    assign full       = (count == DEPTH_C);
    assign out_data   = mem[rd_ptr];
    assign busy       = (used != '0) || (state == FLUSH);
    assign flush_done = (state == FLUSH) && !flush && (vsr == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            vsr   <= '0;
            used  <= '0;
        end else begin
            vsr <= {vsr[LATENCY-2:0], accept};

            if (flush) begin
                state <= FLUSH;
            end else begin
                case (state)
                    IDLE:    if (enable)     state <= RUN;
                    RUN:     if (!enable)    state <= IDLE;
                    FLUSH:   if (vsr == '0)  state <= IDLE;
                    default:                 state <= IDLE;
                endcase
            end

            if (flush_done)
                used <= '0;
            else if (accept && !pop)
                used <= used + (AW+1)'(1);
            else if (pop && !accept)
                used <= used - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err_ovf <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (wr && full && !pop)
                err_ovf <= 1'b1;

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (wr) begin
                    mem[wr_ptr] <= model_out;
                    wr_ptr      <= wr_ptr + AW'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                case ({wr, pop})
                    2'b10:   count <= count + (AW+1)'(1);
                    2'b01:   count <= count - (AW+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ml_model_sched.sv
// tb_ml_model_sched
//   Bench for ml_model_sched. A stand-in ml_model (6 register stages applying a
//   fixed transform) sits behind the controller. A queue-based reference tracks
//   accepted vectors, their due cycle and the result FIFO contents.

module tb_ml_model_sched;

    localparam int IN_W  = 120;
    localparam int OUT_W = 140;
    localparam int LAT   = 6;
    localparam int DEPTH = 8;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FLUSH = 2;

    logic             clk = 1'b0;
    logic             resetn;
    logic             enable;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [IN_W-1:0]  model_inp;
    logic [OUT_W-1:0] model_out;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [3:0]       used;
    logic             busy;
    logic             err_ovf;

    always #5 clk = ~clk;

    ml_model_sched #(.IN_W(IN_W), .OUT_W(OUT_W), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .model_inp(model_inp), .model_out(model_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .used(used), .busy(busy), .err_ovf(err_ovf)
    );

    function automatic logic [OUT_W-1:0] fmod(input logic [IN_W-1:0] x);
        return {x[19:0] ^ 20'hA5A5A, ~x};
    endfunction

    // Stand-in ml_model: 5 stages plus output register.
    logic [OUT_W-1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= fmod(model_inp);
        for (int i = 1; i < LAT; i++)
            pipe[i] <= pipe[i-1];
    end
    assign model_out = pipe[LAT-1];

    typedef struct {
        logic [OUT_W-1:0] d;
        int               due;
    } item_t;

    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    int               mode;
    int               outst;
    logic [OUT_W-1:0] fifo_q[$];
    item_t            infl[$];

    int dut_acc = 0;
    int dut_pop = 0;
    int ir_low  = 0;
    int first_ov = -1;
    int last_acc = 0;

    task automatic check(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mode  = M_IDLE;
        outst = 0;
        fifo_q.delete();
        infl.delete();
    endtask

    // Called at posedge+1 with this cycle's inputs already driven; checks the
    // outputs, advances the reference across the coming edge, returns at the
    // next posedge+1.
    task automatic step();
        logic  exp_ir, exp_ov, acc, pp, pipe_busy;
        item_t it;
        #2;
        exp_ir = (mode == M_RUN) && (outst < DEPTH);
        exp_ov = (fifo_q.size() != 0) && (mode != M_FLUSH);
        check("in_ready", in_ready, exp_ir);
        check("out_valid", out_valid, exp_ov);
        check("used", used, outst);
        check("busy", busy, (outst != 0) || (mode == M_FLUSH));
        check("err_ovf", err_ovf, 1'b0);
        if (exp_ov) check("out_data", out_data, fifo_q[0]);

        if (in_valid && in_ready) dut_acc++;
        if (out_valid && out_ready) dut_pop++;
        if (in_valid && !in_ready) ir_low++;
        if (out_valid && first_ov < 0) first_ov = cyc;

        acc       = in_valid && exp_ir;
        pp        = exp_ov && out_ready;
        pipe_busy = (infl.size() != 0);

        if (pp) void'(fifo_q.pop_front());
        if (infl.size() != 0 && infl[0].due == cyc) begin
            it = infl.pop_front();
            if (!flush && mode != M_FLUSH) fifo_q.push_back(it.d);
        end
        if (flush) fifo_q.delete();

        outst = outst + (acc ? 1 : 0) - (pp ? 1 : 0);
        if (mode == M_FLUSH && !flush && !pipe_busy) outst = 0;

        if (flush) mode = M_FLUSH;
        else if (mode == M_IDLE && enable) mode = M_RUN;
        else if (mode == M_RUN && !enable) mode = M_IDLE;
        else if (mode == M_FLUSH && !pipe_busy) mode = M_IDLE;

        if (acc) begin
            it.d   = fmod(in_data);
            it.due = cyc + LAT;
            infl.push_back(it);
            last_acc = cyc;
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [IN_W-1:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, p0, n, acc_c;
        resetn = 1'b0; enable = 1'b0; flush = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        model_reset();
        #3;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_used", used, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_err_ovf", err_ovf, 1'b0);
        in_data = rnd();
        #1;
        check("rst_model_inp", model_inp, in_data);
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (2) step();

        // Single vector latency
        enable = 1'b1;
        step();
        in_valid = 1'b1; in_data = rnd();
        step();
        acc_c = last_acc;
        in_valid = 1'b0; out_ready = 1'b1; first_ov = -1;
        repeat (12) step();
        check("t1_latency", first_ov - acc_c, 7);
        check("t1_used", used, 0);

        // Backpressure: 8 credits then stall
        out_ready = 1'b0;
        a0 = dut_acc;
        repeat (12) begin
            in_valid = 1'b1; in_data = rnd();
            step();
        end
        check("t2_accepts", dut_acc - a0, 8);
        check("t2_used_full", used, 8);
        check("t2_in_ready_low", in_ready, 1'b0);
        in_valid = 1'b0; out_ready = 1'b1; p0 = dut_pop;
        repeat (12) step();
        check("t2_results", dut_pop - p0, 8);
        check("t2_in_ready_back", in_ready, 1'b1);

        // Full throughput
        ir_low = 0; a0 = dut_acc; p0 = dut_pop; n = 0;
        while (dut_acc - a0 < 100 && n < 200) begin
            in_valid = 1'b1; in_data = rnd();
            step();
            n++;
        end
        in_valid = 1'b0;
        repeat (10) step();
        check("t3_accepts", dut_acc - a0, 100);
        check("t3_results", dut_pop - p0, 100);
        check("t3_in_ready_drops", ir_low, 0);

        // Flush with 2 in FIFO and 3 in pipeline
        out_ready = 1'b0;
        repeat (2) begin in_valid = 1'b1; in_data = rnd(); step(); end
        in_valid = 1'b0;
        repeat (6) step();
        repeat (3) begin in_valid = 1'b1; in_data = rnd(); step(); end
        in_valid = 1'b0;
        check("t4_used_before", used, 5);
        flush = 1'b1;
        step();
        flush = 1'b0; out_ready = 1'b1;
        check("t4_out_valid_off", out_valid, 1'b0);
        p0 = dut_pop; n = 0;
        while (busy && n < 20) begin step(); n++; end
        check("t4_flush_len_ok", n <= 6, 1'b1);
        check("t4_no_results", dut_pop - p0, 0);
        check("t4_used_zero", used, 0);

        // Enable drop mid-stream
        enable = 1'b1; out_ready = 1'b1;
        repeat (2) step();
        repeat (4) begin in_valid = 1'b1; in_data = rnd(); step(); end
        p0 = dut_pop; a0 = dut_acc;
        enable = 1'b0; in_data = rnd();
        step();
        check("t5_in_ready_off", in_ready, 1'b0);
        repeat (3) begin in_data = rnd(); step(); end
        in_valid = 1'b0;
        repeat (10) step();
        check("t5_delivered", dut_pop - p0, 4 + (dut_acc - a0));
        check("t5_used_zero", used, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) enable = ~enable;
            flush     = ($urandom_range(0, 60) == 0);
            in_valid  = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = rnd();
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (12) step();

        // Reset with 5 outstanding
        enable = 1'b1; out_ready = 1'b0;
        repeat (2) step();
        repeat (5) begin in_valid = 1'b1; in_data = rnd(); step(); end
        in_valid = 1'b0;
        repeat (7) step();
        check("t6_used_before", used, 5);
        resetn = 1'b0;
        #1;
        model_reset();
        check("t6_in_ready", in_ready, 1'b0);
        check("t6_out_valid", out_valid, 1'b0);
        check("t6_out_data", out_data, '0);
        check("t6_used", used, 0);
        check("t6_busy", busy, 1'b0);
        check("t6_err_ovf", err_ovf, 1'b0);
        @(posedge clk); #1;
        resetn = 1'b1; enable = 1'b0;
        repeat (8) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
